// File: rtl/io_bus_stream_fifo.sv
// Memory-mapped 16-bit write FIFO with a ready/valid stream output.
// Three bus registers: DATA (push), STATUS (level/flags), CTRL (threshold, flush, irq enable).
module io_bus_stream_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          DEPTH     = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] io_address,
  input  logic        io_bus_enable,
  input  logic [1:0]  io_byte_enable,
  input  logic        io_rw,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        io_acknowledge,
  output logic        io_irq,
  output logic [15:0] st_data,
  output logic        st_valid,
  input  logic        st_ready
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RELEASE} state_t;

  state_t        state_q;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    thr_q, thr_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_d;
  logic          ack_q, irq_q;
  logic [15:0]   rdata_q, rdata_d;

  logic       hit, access, wr_acc, rd_acc;
  logic [1:0] offset;
  logic       push_req, do_push, pop, flush, ovf_clr, full, empty;

  logic unused_addr_bit;
  assign unused_addr_bit = io_address[0];

  always_comb begin
    hit      = (io_address[15:3] == BASE_ADDR[15:3]);
    offset   = io_address[2:1];
    access   = (state_q == S_IDLE) && io_bus_enable && hit;
    wr_acc   = access && !io_rw;
    rd_acc   = access && io_rw;
    full     = (level_q == DEPTH_L);
    empty    = (level_q == 9'd0);
    push_req = wr_acc && (offset == 2'd0) && (io_byte_enable == 2'b11);
    flush    = wr_acc && (offset == 2'd2) && io_byte_enable[1] && io_write_data[14];
    ovf_clr  = wr_acc && (offset == 2'd1) && io_byte_enable[1] && io_write_data[14];
    pop      = !empty && st_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push  = push_req && (!full || pop);

    thr_d    = thr_q;
    irq_en_d = irq_en_q;
    if (wr_acc && (offset == 2'd2)) begin
      if (io_byte_enable[0]) thr_d    = io_write_data[7:0];
      if (io_byte_enable[1]) irq_en_d = io_write_data[15];
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   level_d = level_q + 9'd1;
        2'b01:   level_d = level_q - 9'd1;
        default: level_d = level_q;
      endcase
      if (push_req && full && !pop) ovf_d = 1'b1;
      else if (ovf_clr)             ovf_d = 1'b0;
    end

    irq_d = irq_en_d && ((level_d <= {1'b0, thr_d}) || ovf_d);

    rdata_d = '0;
    if (rd_acc) begin
      case (offset)
        2'd1:    rdata_d = {1'b0, ovf_q, full, empty, 3'b000, level_q};
        2'd2:    rdata_d = {irq_en_q, 7'b0, thr_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      thr_q    <= '0;
      irq_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    if (access) state_q <= S_ACK;
        S_ACK:     state_q <= S_RELEASE;
        S_RELEASE: if (!io_bus_enable) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
      ack_q    <= access;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      thr_q    <= thr_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Storage is left unreset; the level count alone decides what is valid.
  always_ff @(posedge clk_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= io_write_data;
  end

  assign io_acknowledge = ack_q;
  assign io_irq         = irq_q;
  assign io_read_data   = rdata_q;
  assign st_valid       = (level_q != 9'd0);
  assign st_data        = st_valid ? mem_q[rd_ptr_q] : 16'h0000;

endmodule

// File: tb/tb_io_bus_stream_fifo.sv
// Directed bench for io_bus_stream_fifo: bus protocol, FIFO level/flags, irq and flush.
module tb_io_bus_stream_fifo;

  localparam logic [15:0] A_DATA = 16'h0100;
  localparam logic [15:0] A_STAT = 16'h0102;
  localparam logic [15:0] A_CTRL = 16'h0104;
  localparam logic [15:0] A_RSV  = 16'h0106;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [15:0] io_address = '0;
  logic        io_bus_enable = 1'b0;
  logic [1:0]  io_byte_enable = '0;
  logic        io_rw = 1'b0;
  logic [15:0] io_write_data = '0;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;
  logic [15:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic        ack_st_valid;
  logic [15:0] ack_st_data;

  always #5 clk_clk = ~clk_clk;

  io_bus_stream_fifo #(.BASE_ADDR(16'h0100), .DEPTH(16)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .io_address(io_address), .io_bus_enable(io_bus_enable),
    .io_byte_enable(io_byte_enable), .io_rw(io_rw), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_acknowledge(io_acknowledge), .io_irq(io_irq),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
  );

  // Called at a falling edge; returns ack latency (0 = none within budget) and ack width.
  task automatic bus(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                     input logic [15:0] wd, output logic [15:0] rd,
                     output int lat, output int width);
    lat = 0; width = 0; rd = '0;
    io_address = addr; io_rw = rw; io_byte_enable = be; io_write_data = wd;
    io_bus_enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_clk);
      if (io_acknowledge) begin
        lat = c; width = 1; rd = io_read_data;
        ack_st_valid = st_valid; ack_st_data = st_data;
        break;
      end
    end
    io_bus_enable = 1'b0;
    repeat (2) begin
      @(negedge clk_clk);
      if (io_acknowledge) width++;
    end
    $display("txn addr=%h rw=%0d be=%b wdata=%h rdata=%h lat=%0d width=%0d",
             addr, rw, be, wd, rd, lat, width);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0; io_bus_enable = 1'b0; st_ready = 1'b0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({io_acknowledge, io_irq, st_valid} !== 3'b000 || io_read_data !== 16'h0 || st_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b irq=%b valid=%b rdata=%h sdata=%h required all 0",
               io_acknowledge, io_irq, st_valid, io_read_data, st_data);
    end
    $display("txn reset checked");
  endtask

  task automatic test_single_write();
    logic [15:0] rd; int lat, w;
    do_reset();
    bus(A_DATA, 1'b0, 2'b11, 16'hA5A5, rd, lat, w);
    checks++;
    if (lat !== 1 || w !== 1) begin
      errors++; $display("FAIL write_ack_timing lat=%0d width=%0d required 1 1", lat, w);
    end
    checks++;
    if (ack_st_valid !== 1'b1 || ack_st_data !== 16'hA5A5) begin
      errors++; $display("FAIL ack_cycle_head valid=%b data=%h required 1 a5a5", ack_st_valid, ack_st_data);
    end
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h0001) begin
      errors++; $display("FAIL status_one got=%h required 0001", rd);
    end
    bus(A_DATA, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h0000 || lat !== 1) begin
      errors++; $display("FAIL data_read got=%h lat=%0d required 0000 1", rd, lat);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] rd; int lat, w;
    do_reset();
    for (int i = 0; i < 17; i++) bus(A_DATA, 1'b0, 2'b11, 16'h1000 + 16'(i), rd, lat, w);
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h6010) begin
      errors++; $display("FAIL status_overflow got=%h required 6010", rd);
    end
    checks++;
    if (st_data !== 16'h1000) begin
      errors++; $display("FAIL overflow_head got=%h required 1000", st_data);
    end
    bus(A_STAT, 1'b0, 2'b11, 16'h4000, rd, lat, w);
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h2010) begin
      errors++; $display("FAIL status_ovf_cleared got=%h required 2010", rd);
    end
  endtask

  task automatic test_irq();
    logic [15:0] rd; int lat, w;
    do_reset();
    bus(A_CTRL, 1'b0, 2'b11, 16'h8002, rd, lat, w);
    checks++;
    if (io_irq !== 1'b1) begin
      errors++; $display("FAIL irq_empty got=%b required 1", io_irq);
    end
    bus(A_CTRL, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h8002) begin
      errors++; $display("FAIL ctrl_readback got=%h required 8002", rd);
    end
    bus(A_DATA, 1'b0, 2'b11, 16'h0011, rd, lat, w);
    bus(A_DATA, 1'b0, 2'b11, 16'h0022, rd, lat, w);
    checks++;
    if (io_irq !== 1'b1) begin
      errors++; $display("FAIL irq_level_eq_thr got=%b required 1", io_irq);
    end
    bus(A_DATA, 1'b0, 2'b11, 16'h0033, rd, lat, w);
    checks++;
    if (io_irq !== 1'b0) begin
      errors++; $display("FAIL irq_above_thr got=%b required 0", io_irq);
    end
    st_ready = 1'b1;
    @(negedge clk_clk);
    st_ready = 1'b0;
    checks++;
    if (io_irq !== 1'b1 || st_data !== 16'h0022) begin
      errors++; $display("FAIL irq_after_pop irq=%b head=%h required 1 0022", io_irq, st_data);
    end
    $display("txn pop one word head=%h irq=%b", st_data, io_irq);
  endtask

  task automatic test_full_push_pop();
    logic [15:0] rd, exp; int lat, w, n_bad;
    logic [15:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus(A_DATA, 1'b0, 2'b11, 16'h2000 + 16'(i), rd, lat, w);
      exp_q.push_back(16'h2000 + 16'(i));
    end
    io_address = A_DATA; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'h3000; io_bus_enable = 1'b1; st_ready = 1'b1;
    @(negedge clk_clk);
    st_ready = 1'b0;
    checks++;
    if (io_acknowledge !== 1'b1) begin
      errors++; $display("FAIL push_pop_ack got=%b required 1", io_acknowledge);
    end
    io_bus_enable = 1'b0;
    repeat (2) @(negedge clk_clk);
    exp = exp_q.pop_front();
    exp_q.push_back(16'h3000);
    $display("txn push 3000 with pop of %h on full fifo", exp);
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h2010) begin
      errors++; $display("FAIL full_push_pop_status got=%h required 2010", rd);
    end
    for (int r = 0; r <= 3; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 8; i++) begin
          bus(A_DATA, 1'b0, 2'b11, 16'h4000 + 16'(r * 8 + i), rd, lat, w);
          exp_q.push_back(16'h4000 + 16'(r * 8 + i));
        end
      end
      n_bad = 0;
      st_ready = 1'b1;
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (st_valid !== 1'b1 || st_data !== exp) begin
          errors++; n_bad++;
          $display("FAIL drain_order valid=%b head=%h required 1 %h", st_valid, st_data, exp);
        end
        @(negedge clk_clk);
      end
      st_ready = 1'b0;
      checks++;
      if (st_valid !== 1'b0 || st_data !== 16'h0) begin
        errors++; $display("FAIL drained_empty valid=%b head=%h required 0 0000", st_valid, st_data);
      end
      $display("txn drain round %0d bad=%0d", r, n_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int lat, w, n_ack;
    do_reset();
    io_address = A_DATA; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'h5A5A; io_bus_enable = 1'b1; n_ack = 0;
    repeat (5) begin
      @(negedge clk_clk);
      if (io_acknowledge) n_ack++;
    end
    io_bus_enable = 1'b0;
    repeat (2) begin
      @(negedge clk_clk);
      if (io_acknowledge) n_ack++;
    end
    $display("txn held write 5a5a acks=%0d", n_ack);
    checks++;
    if (n_ack !== 1) begin
      errors++; $display("FAIL held_enable_acks got=%0d required 1", n_ack);
    end
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h0001) begin
      errors++; $display("FAIL held_enable_level got=%h required 0001", rd);
    end
    bus(16'h0200, 1'b0, 2'b11, 16'h1111, rd, lat, w);
    checks++;
    if (lat !== 0 || w !== 0) begin
      errors++; $display("FAIL miss_ack lat=%0d width=%0d required 0 0", lat, w);
    end
    bus(A_DATA, 1'b0, 2'b01, 16'h2222, rd, lat, w);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL be01_ack lat=%0d required 1", lat);
    end
    bus(A_RSV, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (lat !== 1 || rd !== 16'h0000) begin
      errors++; $display("FAIL reserved_read lat=%0d got=%h required 1 0000", lat, rd);
    end
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h0001 || st_data !== 16'h5A5A) begin
      errors++; $display("FAIL no_extra_push status=%h head=%h required 0001 5a5a", rd, st_data);
    end
  endtask

  task automatic test_flush();
    logic [15:0] rd; int lat, w;
    do_reset();
    for (int i = 0; i < 7; i++) bus(A_DATA, 1'b0, 2'b11, 16'h7000 + 16'(i), rd, lat, w);
    io_address = A_CTRL; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'h4000; io_bus_enable = 1'b1; st_ready = 1'b1;
    @(negedge clk_clk);
    st_ready = 1'b0;
    checks++;
    if (io_acknowledge !== 1'b1 || st_valid !== 1'b0) begin
      errors++; $display("FAIL flush_edge ack=%b valid=%b required 1 0", io_acknowledge, st_valid);
    end
    io_bus_enable = 1'b0;
    repeat (2) @(negedge clk_clk);
    $display("txn flush with level 7");
    bus(A_STAT, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h1000) begin
      errors++; $display("FAIL flush_status got=%h required 1000", rd);
    end
    bus(A_CTRL, 1'b1, 2'b11, 16'h0, rd, lat, w);
    checks++;
    if (rd !== 16'h0000) begin
      errors++; $display("FAIL flush_self_clear got=%h required 0000", rd);
    end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    do_reset();
    io_address = A_DATA; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'hBEEF; io_bus_enable = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (io_acknowledge !== 1'b1) begin
      errors++; $display("FAIL mid_ack_before got=%b required 1", io_acknowledge);
    end
    reset_reset_n = 1'b0; io_bus_enable = 1'b0;
    @(negedge clk_clk);
    checks++;
    if ({io_acknowledge, io_irq, st_valid} !== 3'b000 || io_read_data !== 16'h0 || st_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs ack=%b irq=%b valid=%b rdata=%h sdata=%h required all 0",
               io_acknowledge, io_irq, st_valid, io_read_data, st_data);
    end
    n_ack = 0;
    reset_reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk_clk);
      if (io_acknowledge) n_ack++;
    end
    checks++;
    if (n_ack !== 0 || st_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after acks=%0d valid=%b required 0 0", n_ack, st_valid);
    end
    $display("txn reset during ack acks_after=%0d", n_ack);
  endtask

  initial begin
    @(negedge clk_clk);
    test_reset();
    test_single_write();
    test_overflow();
    test_irq();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
